// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed active-low 7-segment bus, decodes each
// stable digit back to a hex nibble and publishes only complete, coherent frames.
module seg_scan_capture #(
    parameter int NUM_DIG    = 6,
    parameter int STABLE_CYC = 16,
    parameter int SYNC_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           seg_data,
    input  logic [NUM_DIG-1:0]   seg_sel,
    output logic [4*NUM_DIG-1:0] hex_value,
    output logic [NUM_DIG-1:0]   dp_flags,
    output logic [NUM_DIG-1:0]   err_flags,
    output logic                 frame_valid,
    output logic                 pattern_err
);
    localparam int CW = $clog2(STABLE_CYC) + 1;
    localparam int SW = NUM_DIG + 8;
    localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [SW-1:0]        sync1_q, sync2_q, prev_q, samp;
    logic [NUM_DIG-1:0]   sel_s, seen_q, seen_d, dp_q, dp_d, err_q, err_d;
    logic [7:0]           seg_s;
    logic [4*NUM_DIG-1:0] nib_q, nib_d;
    logic [IW-1:0]        idx;
    logic [4:0]           dec;
    logic                 valid, same, capture;

    // returns {undecodable, nibble}; dp is handled separately
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = 5'h00;
            7'h79: decode = 5'h01;
            7'h24: decode = 5'h02;
            7'h30: decode = 5'h03;
            7'h19: decode = 5'h04;
            7'h12: decode = 5'h05;
            7'h02: decode = 5'h06;
            7'h78: decode = 5'h07;
            7'h00: decode = 5'h08;
            7'h10: decode = 5'h09;
            7'h08: decode = 5'h0A;
            7'h03: decode = 5'h0B;
            7'h46: decode = 5'h0C;
            7'h21: decode = 5'h0D;
            7'h06: decode = 5'h0E;
            7'h0E: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign samp    = (SYNC_EN != 0) ? sync2_q : sync1_q;
    assign sel_s   = samp[SW-1:8];
    assign seg_s   = samp[7:0];
    assign valid   = $onehot(~sel_s);
    assign same    = samp == prev_q;
    assign dec     = decode(seg_s[6:0]);
    assign capture = (state_q == SETTLE) && valid && same && (cnt_q == CW'(STABLE_CYC - 1));

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIG; i++)
            if (!sel_s[i]) idx = IW'(i);
    end

    always_comb begin
        nib_d = nib_q;
        dp_d = dp_q;
        err_d = err_q;
        seen_d = seen_q | (NUM_DIG'(1) << idx);
        nib_d[4*int'(idx) +: 4] = dec[3:0];
        dp_d[idx] = ~seg_s[7];
        err_d[idx] = dec[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q <= '1;
            seen_q <= '0;
            nib_q <= '0;
            dp_q <= '0;
            err_q <= '0;
            hex_value <= '0;
            dp_flags <= '0;
            err_flags <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            sync1_q <= {seg_sel, seg_data};
            sync2_q <= sync1_q;
            prev_q <= samp;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            case (state_q)
                IDLE: if (valid) begin
                    state_q <= SETTLE;
                    cnt_q <= CW'(1);
                end
                SETTLE: if (!valid) begin
                    state_q <= IDLE;
                    cnt_q <= '0;
                end else if (!same) begin
                    cnt_q <= CW'(1);
                end else if (capture) begin
                    state_q <= CAPTURED;
                end else begin
                    cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
                default: if (!valid) begin
                    state_q <= IDLE;
                    cnt_q <= '0;
                end else if (!same) begin
                    state_q <= SETTLE;
                    cnt_q <= CW'(1);
                end
            endcase
            if (capture) begin
                nib_q <= nib_d;
                dp_q <= dp_d;
                err_q <= err_d;
                pattern_err <= dec[4];
                seen_q <= (&seen_d) ? '0 : seen_d;
                if (&seen_d) begin
                    hex_value <= nib_d;
                    dp_flags <= dp_d;
                    err_flags <= err_d;
                    frame_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: scoreboard bench; expected frames are queued as scans are
// driven and compared whenever the capture block publishes a frame.
module tb_seg_scan_capture;
    typedef struct packed {
        logic [23:0] hex;
        logic [5:0]  dp;
        logic [5:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_data = 8'hFF;
    logic [5:0]  seg_sel = 6'h3F;
    logic [23:0] hex_value;
    logic [5:0]  dp_flags, err_flags;
    logic        frame_valid, pattern_err;

    frame_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int pe_cnt = 0;

    seg_scan_capture dut (
        .clk(clk), .rst(rst), .seg_data(seg_data), .seg_sel(seg_sel),
        .hex_value(hex_value), .dp_flags(dp_flags), .err_flags(err_flags),
        .frame_valid(frame_valid), .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pattern_err) pe_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(hex_value), 32'hFFFFFFFF);
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    chk("frame_hex", 32'(hex_value), 32'(e.hex));
                    chk("frame_dp", 32'(dp_flags), 32'(e.dp));
                    chk("frame_err", 32'(err_flags), 32'(e.err));
                end
            end
        end
    end

    task automatic show(input int d, input logic [7:0] p, input int n);
        seg_sel = ~(6'b000001 << d);
        seg_data = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        seg_sel = 6'h3F;
        seg_data = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [47:0] pats, input int lo);
        for (int d = 5; d >= lo; d--) show(d, pats[8*d +: 8], 20);
    endtask

    task automatic chk_outs(input string tag, input logic [23:0] h, input logic [5:0] dp, input logic [5:0] er);
        chk({tag, "_hex"}, 32'(hex_value), 32'(h));
        chk({tag, "_dp"}, 32'(dp_flags), 32'(dp));
        chk({tag, "_err"}, 32'(err_flags), 32'(er));
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk_outs("rst0", 24'h0, 6'h0, 6'h0);
        chk("rst0_fv", 32'(frame_valid), 32'h0);
        chk("rst0_pe", 32'(pattern_err), 32'h0);
        // partial frame then reset mid-settle: leftover seen bits must not survive
        show(2, 8'hC0, 20);
        show(1, 8'hC0, 20);
        show(0, 8'hC0, 20);
        show(5, 8'hF9, 8);
        seg_sel = 6'h3F;
        seg_data = 8'hFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(100);
        chk_outs("t1", 24'h0, 6'h0, 6'h0);
        chk("t1_no_frame", 32'(fv_cnt), 32'd0);

        exp_q.push_back('{24'h12AB9F, 6'h00, 6'h00});
        scan(48'hF9A48883908E, 0);
        idle(30);
        chk("t2_frames", 32'(fv_cnt), 32'd1);
        chk("t2_pending", 32'(exp_q.size()), 32'd0);
        chk("t2_pe", 32'(pe_cnt), 32'd0);
        chk_outs("t2_hold", 24'h12AB9F, 6'h00, 6'h00);

        show(0, 8'hC0, 10);
        idle(40);
        chk("t3_frames", 32'(fv_cnt), 32'd1);
        chk("t3_pe", 32'(pe_cnt), 32'd0);
        chk_outs("t3_hold", 24'h12AB9F, 6'h00, 6'h00);

        exp_q.push_back('{24'h12A09F, 6'h00, 6'b000100});
        scan(48'hF9A488FF908E, 0);
        idle(30);
        chk("t4_frames", 32'(fv_cnt), 32'd2);
        chk("t4_pe", 32'(pe_cnt), 32'd1);
        chk("t4_pending", 32'(exp_q.size()), 32'd0);

        exp_q.push_back('{24'h120B9F, 6'b001000, 6'h00});
        scan(48'hF9A44083908E, 0);
        idle(30);
        chk("t5_frames", 32'(fv_cnt), 32'd3);
        chk("t5_pending", 32'(exp_q.size()), 32'd0);

        // two selects low must never count as a capture of digit 0 or 1
        scan(48'hF9A48883908E, 1);
        seg_sel = 6'b111100;
        seg_data = 8'hFF;
        repeat (50) @(negedge clk);
        chk("t6_frames", 32'(fv_cnt), 32'd3);
        chk("t6_pe", 32'(pe_cnt), 32'd1);
        exp_q.push_back('{24'h12AB90, 6'h00, 6'h00});
        show(0, 8'hC0, 20);
        idle(30);
        chk("t6_done", 32'(fv_cnt), 32'd4);
        chk("t6_pending", 32'(exp_q.size()), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_outs("rst_end", 24'h0, 6'h0, 6'h0);
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
